cp_insert: RTL and testbench

- Sits directly downstream of the IFFT stage and consumes its 64-sample output frames: sample, per-frame block exponent, and output index.
- Buffers each frame in a ping-pong RAM.
- Emits 80-sample OFDM symbols: a 16-sample cyclic prefix (samples 48..63), then samples 0..63.
- The block exponent is carried unchanged alongside each output symbol.

---
 rtl/ofdm_pkg.sv | 22 ++
 rtl/cp_bank_ram.sv | 24 ++
 rtl/cp_insert.sv | 182 ++++++++++++++++++
 tb/tb_cp_insert.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared constants and FSM state types for the OFDM transmit back end.
package ofdm_pkg;

    localparam int NFFT    = 64;
    localparam int NCP     = 16;
    localparam int SYM_LEN = NFFT + NCP;
    localparam int WIDTH   = 16;
    localparam int EXPW    = 6;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_DROP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CP,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/cp_bank_ram.sv
// Simple dual-port ping-pong frame store; address is {bank, index}, registered read.
module cp_bank_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          cp_clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array and its read register have no reset so they map onto block RAM;
    // consumers qualify rd_data with their own reset-cleared valid.
    always_ff @(posedge cp_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cp_insert.sv
// Buffers 64-sample IFFT frames in a ping-pong RAM and replays each as an
// 80-sample symbol: cyclic prefix (last NCP samples) followed by the full frame.
module cp_insert import ofdm_pkg::*; #(
    parameter int WIDTH = ofdm_pkg::WIDTH,
    parameter int EXPW  = ofdm_pkg::EXPW,
    parameter int NFFT  = ofdm_pkg::NFFT,
    parameter int NCP   = ofdm_pkg::NCP
) (
    input  logic                          cp_clk,
    input  logic                          cp_rst_n,
    input  logic                          din_valid,
    input  logic [$clog2(NFFT)-1:0]       din_index,
    input  logic [WIDTH-1:0]              din_real,
    input  logic [WIDTH-1:0]              din_imag,
    input  logic [EXPW-1:0]               din_exp,
    output logic                          dout_valid,
    output logic                          dout_sop,
    output logic                          dout_eop,
    output logic [$clog2(NFFT+NCP)-1:0]   dout_index,
    output logic [WIDTH-1:0]              dout_real,
    output logic [WIDTH-1:0]              dout_imag,
    output logic [EXPW-1:0]               dout_exp,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(NFFT);
    localparam int PW = $clog2(NFFT + NCP);
    localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);
    localparam logic [PW-1:0] CP_LAST  = PW'(NCP - 1);
    localparam logic [PW-1:0] SYM_LAST = PW'(NFFT + NCP - 1);
    localparam logic [PW-1:0] CP_OFS   = PW'(NFFT - NCP);

    wr_state_e          wr_state, wr_state_nx;
    logic               wr_ptr;
    logic [AW-1:0]      wr_cnt, wr_cnt_nx;
    logic               wr_en, wr_start, wr_done, ovf_nx, err_nx;
    logic [1:0]         bank_full;
    logic [EXPW-1:0]    bank_exp [2];

    rd_state_e          rd_state, rd_state_nx;
    logic               rd_ptr;
    logic [PW-1:0]      rd_pos, rd_pos_nx, rd_sum;
    logic               rd_issue, rd_done;
    logic [2*WIDTH-1:0] rd_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_state_nx = wr_state;
        wr_cnt_nx   = wr_cnt;
        wr_en       = 1'b0;
        wr_start    = 1'b0;
        wr_done     = 1'b0;
        ovf_nx      = 1'b0;
        err_nx      = 1'b0;
        case (wr_state)
            WR_IDLE: if (din_valid) begin
                if (din_index != '0) begin
                    err_nx      = 1'b1;
                    wr_state_nx = WR_DROP;
                end else if (bank_full[wr_ptr]) begin
                    ovf_nx      = 1'b1;
                    wr_state_nx = WR_DROP;
                end else begin
                    wr_en       = 1'b1;
                    wr_start    = 1'b1;
                    wr_cnt_nx   = AW'(1);
                    wr_state_nx = WR_FILL;
                end
            end
            WR_FILL: if (!din_valid) begin
                err_nx      = 1'b1;
                wr_state_nx = WR_IDLE;
            end else if (din_index != wr_cnt) begin
                err_nx      = 1'b1;
                wr_state_nx = WR_DROP;
            end else begin
                wr_en     = 1'b1;
                wr_cnt_nx = wr_cnt + AW'(1);
                if (wr_cnt == LAST_IDX) begin
                    wr_done     = 1'b1;
                    wr_state_nx = WR_IDLE;
                end
            end
            WR_DROP: if (!din_valid) wr_state_nx = WR_IDLE;
            default: wr_state_nx = WR_IDLE;
        endcase
    end

    // Position 0..SYM_LEN-1 maps to frame address (pos + NFFT-NCP) mod NFFT.
    assign rd_sum = rd_pos + CP_OFS;

    always_comb begin
        rd_state_nx = rd_state;
        rd_pos_nx   = rd_pos;
        rd_issue    = 1'b0;
        rd_done     = 1'b0;
        case (rd_state)
            RD_IDLE: if (bank_full[rd_ptr]) begin
                rd_state_nx = RD_CP;
                rd_pos_nx   = '0;
            end
            RD_CP: begin
                rd_issue  = 1'b1;
                rd_pos_nx = rd_pos + PW'(1);
                if (rd_pos == CP_LAST) rd_state_nx = RD_DATA;
            end
            RD_DATA: begin
                rd_issue  = 1'b1;
                rd_pos_nx = rd_pos + PW'(1);
                if (rd_pos == SYM_LAST) begin
                    rd_done     = 1'b1;
                    rd_pos_nx   = '0;
                    rd_state_nx = bank_full[~rd_ptr] ? RD_CP : RD_IDLE;
                end
            end
            default: rd_state_nx = RD_IDLE;
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge cp_clk or negedge cp_rst_n) begin
        if (!cp_rst_n) begin
            wr_state    <= WR_IDLE;
            wr_cnt      <= '0;
            wr_ptr      <= 1'b0;
            rd_state    <= RD_IDLE;
            rd_pos      <= '0;
            rd_ptr      <= 1'b0;
            bank_full   <= '0;
            bank_exp[0] <= '0;
            bank_exp[1] <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            dout_valid  <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            dout_index  <= '0;
            dout_exp    <= '0;
        end else begin
            wr_state  <= wr_state_nx;
            wr_cnt    <= wr_cnt_nx;
            rd_state  <= rd_state_nx;
            rd_pos    <= rd_pos_nx;
            overflow  <= ovf_nx;
            frame_err <= err_nx;
            if (wr_start) bank_exp[wr_ptr] <= din_exp;
            if (wr_done) begin
                bank_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
            // The writer never targets the bank being read, so set and clear hit different bits.
            if (rd_done) begin
                bank_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            dout_valid <= rd_issue;
            dout_sop   <= rd_issue && (rd_pos == '0);
            dout_eop   <= rd_done;
            dout_index <= rd_issue ? rd_pos : '0;
            if (rd_issue && (rd_pos == '0)) dout_exp <= bank_exp[rd_ptr];
        end
    end

    cp_bank_ram #(
        .DW(2 * WIDTH),
        .AW(AW + 1)
    ) u_ram (
        .cp_clk  (cp_clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_ptr, din_index}),
        .wr_data ({din_real, din_imag}),
        .rd_en   (rd_issue),
        .rd_addr ({rd_ptr, rd_sum[AW-1:0]}),
        .rd_data (rd_data)
    );

    // The RAM read register is the output stage; gate it so idle data reads as zero.
    assign dout_real = dout_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign dout_imag = dout_valid ? rd_data[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: accepted frames push their expected 80-sample
// symbol; a negedge monitor pops and compares every valid output sample.
module tb_cp_insert;
    import ofdm_pkg::*;

    localparam int W = ofdm_pkg::WIDTH;
    localparam int E = ofdm_pkg::EXPW;

    logic           cp_clk = 1'b0;
    logic           cp_rst_n = 1'b1;
    logic           din_valid = 1'b0;
    logic [5:0]     din_index = '0;
    logic [W-1:0]   din_real = '0;
    logic [W-1:0]   din_imag = '0;
    logic [E-1:0]   din_exp = '0;
    logic           dout_valid, dout_sop, dout_eop, overflow, frame_err;
    logic [6:0]     dout_index;
    logic [W-1:0]   dout_real, dout_imag;
    logic [E-1:0]   dout_exp;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [E-1:0] ex;
        int           idx;
    } exp_t;

    exp_t sb[$];
    int   sop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ovf_cnt = 0;
    int   err_cnt = 0;
    int   t63 = 0;

    cp_insert dut (
        .cp_clk     (cp_clk),
        .cp_rst_n   (cp_rst_n),
        .din_valid  (din_valid),
        .din_index  (din_index),
        .din_real   (din_real),
        .din_imag   (din_imag),
        .din_exp    (din_exp),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .dout_index (dout_index),
        .dout_real  (dout_real),
        .dout_imag  (dout_imag),
        .dout_exp   (dout_exp),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 cp_clk = ~cp_clk;
    always @(posedge cp_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
        end
    endtask

    always @(negedge cp_clk) begin
        if (cp_rst_n) begin
            if (overflow) ovf_cnt++;
            if (frame_err) err_cnt++;
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(dout_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("real", 32'(dout_real), 32'(e.re));
                    check("imag", 32'(dout_imag), 32'(e.im));
                    check("exp", 32'(dout_exp), 32'(e.ex));
                    check("index", 32'(dout_index), 32'(e.idx));
                    check("sop", 32'(dout_sop), 32'(e.idx == 0));
                    check("eop", 32'(dout_eop), 32'(e.idx == 79));
                    if (dout_sop) sop_cyc.push_back(cyc);
                end
            end else begin
                check("idle_data", {dout_real, dout_imag}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge cp_clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input int idx, input int base, input logic [E-1:0] ex);
        din_valid = 1'b1;
        din_index = 6'(idx);
        din_real  = W'(base + idx);
        din_imag  = W'(-(base + idx));
        din_exp   = ex;
        tick();
    endtask

    // Drives one clean frame; the caller decides whether it must appear at the output.
    task automatic send_frame(input int base, input logic [E-1:0] ex, input bit accepted);
        if (accepted) begin
            for (int p = 0; p < 80; p++) begin
                exp_t e;
                int   s;
                s     = (p < 16) ? p + 48 : p - 16;
                e.re  = W'(base + s);
                e.im  = W'(-(base + s));
                e.ex  = ex;
                e.idx = p;
                sb.push_back(e);
            end
        end
        for (int k = 0; k < 64; k++) drive(k, base, ex);
        t63 = cyc;
        din_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 800 && sb.size() != 0; i++) tick();
        idle(4);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    function automatic int last_sop();
        return (sop_cyc.size() == 0) ? -1 : sop_cyc[sop_cyc.size() - 1];
    endfunction

    initial begin
        bit found;
        #1 cp_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", 32'({dout_valid, dout_sop, dout_eop, overflow, frame_err, dout_index, dout_exp}), 32'd0);
        check("rst_data", {dout_real, dout_imag}, 32'd0);
        cp_rst_n = 1'b1;
        idle(3);

        // Single frame: real k, imag -k, exponent 5.
        sop_cyc.delete();
        send_frame(0, 6'd5, 1'b1);
        drain("drain_single");
        check("latency_single", 32'(last_sop()), 32'(t63 + 2));

        // Three frames at exactly the sustainable 80-cycle spacing.
        sop_cyc.delete();
        for (int f = 0; f < 3; f++) begin
            send_frame(100 * (f + 1), E'(f + 1), 1'b1);
            idle(16);
        end
        drain("drain_three");
        check("sop_count_three", 32'(sop_cyc.size()), 32'd3);
        if (sop_cyc.size() == 3) begin
            check("gapless_12", 32'(sop_cyc[1] - sop_cyc[0]), 32'd80);
            check("gapless_23", 32'(sop_cyc[2] - sop_cyc[1]), 32'd80);
        end
        check("ovf_three", 32'(ovf_cnt), 32'd0);

        // 64-cycle spacing: third frame hits a full bank; one idle cycle lets the
        // dropping writer rearm before the fourth frame.
        send_frame(1000, 6'd7, 1'b1);
        send_frame(2000, 6'd8, 1'b1);
        send_frame(3000, 6'd9, 1'b0);
        idle(1);
        send_frame(4000, 6'd10, 1'b1);
        drain("drain_ovf");
        check("ovf_count", 32'(ovf_cnt), 32'd1);
        check("err_after_ovf", 32'(err_cnt), 32'd0);

        // din_valid dropped after index 30.
        for (int k = 0; k <= 30; k++) drive(k, 500, 6'd20);
        idle(6);
        check("err_valid_drop", 32'(err_cnt), 32'd1);
        send_frame(5000, 6'd11, 1'b1);
        drain("drain_after_drop");

        // Index skip 9 -> 11; remainder ignored until din_valid falls.
        for (int k = 0; k <= 9; k++) drive(k, 600, 6'd21);
        for (int k = 11; k <= 20; k++) drive(k, 600, 6'd21);
        idle(6);
        check("err_skip", 32'(err_cnt), 32'd2);
        send_frame(6000, 6'd12, 1'b1);
        drain("drain_after_skip");
        check("ovf_final", 32'(ovf_cnt), 32'd1);

        // Reset in the middle of a symbol.
        send_frame(7000, 6'd13, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (dout_valid && dout_index == 7'd40) found = 1'b1;
            else tick();
        end
        check("reach_idx40", 32'(found), 32'd1);
        cp_rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({dout_valid, dout_sop, dout_eop, overflow, frame_err, dout_index, dout_exp}), 32'd0);
        check("midrst_data", {dout_real, dout_imag}, 32'd0);
        sb.delete();
        repeat (3) tick();
        cp_rst_n = 1'b1;
        idle(100);
        sop_cyc.delete();
        send_frame(8000, 6'd14, 1'b1);
        drain("drain_after_rst");
        check("latency_after_rst", 32'(last_sop()), 32'(t63 + 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
